xex_sector_sequencer: RTL and testbench

Sequences one whole disk sector through the XEX encryption engine. Accepts a sector request (sector number, direction, block count) from the AHB-side controller and starts the engine's tweak computation. Then streams the sector's 128-bit blocks one at a time through the engine with valid/ready handshakes on both sides. Signals completion or a timeout error, so the bus controller never drives the engine's `mode`/`in_rdy` pins directly.

---
 rtl/xex_sector_sequencer.sv | 141 ++++++++++++++
 tb/tb_xex_sector_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xex_sector_sequencer.sv
// Sector-level sequencer for the XEX engine: accepts a sector request, waits for the
// engine's tweak computation, then streams blocks through it one at a time.
module xex_sector_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dec,
  input  logic [127:0] req_sector,
  input  logic [7:0]   req_nblk,
  input  logic         blk_in_valid,
  output logic         blk_in_ready,
  input  logic [127:0] blk_in_data,
  output logic         blk_out_valid,
  input  logic         blk_out_ready,
  output logic [127:0] blk_out_data,
  output logic         done,
  output logic         err,
  output logic [1:0]   xex_mode,
  output logic [127:0] xex_sector,
  output logic         xex_in_rdy,
  output logic [127:0] xex_data_in,
  input  logic         xex_busy,
  input  logic         xex_out_rdy,
  input  logic [127:0] xex_data_out
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_TWK,
    S_FEED,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          dec;
  logic          dec_nx;
  logic [7:0]    cnt;
  logic [TW-1:0] tcnt;
  logic          expired;
  logic          timed;
  logic          active_nx;
  logic [1:0]    mode_nx;

  assign req_ready     = (state == S_IDLE);
  assign blk_in_ready  = (state == S_FEED);
  assign blk_out_valid = (state == S_DRAIN);

  always_comb begin
    state_nx  = state;
    expired   = (tcnt == TO_LAST);
    timed     = 1'b0;
    dec_nx    = dec;
    active_nx = 1'b0;
    mode_nx   = 2'b00;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          dec_nx   = req_dec;
          state_nx = (req_nblk == 8'd0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        timed = 1'b1;
        if (xex_busy)     state_nx = S_TWK;
        else if (expired) state_nx = S_ERR;
      end
      S_TWK: begin
        timed = 1'b1;
        if (!xex_busy)    state_nx = S_FEED;
        else if (expired) state_nx = S_ERR;
      end
      S_FEED: begin
        if (blk_in_valid) state_nx = S_ISSUE;
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // the awaited strobe is checked first so it wins in the final cycle
        timed = 1'b1;
        if (xex_out_rdy)  state_nx = S_DRAIN;
        else if (expired) state_nx = S_ERR;
      end
      S_DRAIN: begin
        if (blk_out_ready) state_nx = (cnt == 8'd1) ? S_DONE : S_FEED;
      end
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    active_nx = (state_nx inside {S_START, S_TWK, S_FEED, S_ISSUE, S_WAIT, S_DRAIN});
    mode_nx   = active_nx ? {1'b1, dec_nx} : 2'b00;
  end

  // registered outputs are computed from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state        <= S_IDLE;
      dec          <= 1'b0;
      cnt          <= '0;
      tcnt         <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      xex_mode     <= 2'b00;
      xex_sector   <= '0;
      xex_in_rdy   <= 1'b0;
      xex_data_in  <= '0;
      blk_out_data <= '0;
    end else begin
      state      <= state_nx;
      dec        <= dec_nx;
      xex_mode   <= mode_nx;
      done       <= (state_nx == S_DONE);
      err        <= (state_nx == S_ERR);
      xex_in_rdy <= (state_nx == S_ISSUE);

      if (state_nx != state) tcnt <= '0;
      else if (timed)        tcnt <= tcnt + TW'(1);

      if (state == S_IDLE && req_valid) begin
        xex_sector <= req_sector;
        cnt        <= req_nblk;
      end
      if (state == S_FEED && blk_in_valid) xex_data_in <= blk_in_data;
      if (state == S_WAIT && xex_out_rdy)  blk_out_data <= xex_data_out;
      if (state == S_DRAIN && blk_out_ready) cnt <= cnt - 8'd1;
      if (state == S_ERR) cnt <= '0;
    end
  end

endmodule

// File: tb/tb_xex_sector_sequencer.sv
// Bench for xex_sector_sequencer: behavioural engine model, scoreboard of expected
// result blocks, and two DUT instances (default TIMEOUT and TIMEOUT=8) sharing stimulus.
module tb_xex_sector_sequencer;

  localparam logic [127:0] KE = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
  localparam logic [127:0] KD = 128'hfedc_ba98_7654_3210_a5a5_5a5a_c3c3_3c3c;

  logic         clk;
  logic         n_rst;
  logic         req_valid;
  logic         req_dec;
  logic [127:0] req_sector;
  logic [7:0]   req_nblk;
  logic         blk_in_valid;
  logic [127:0] blk_in_data;
  logic         blk_out_ready;
  logic         xex_busy;
  logic         xex_out_rdy;
  logic [127:0] xex_data_out;

  logic         a_req_ready, b_req_ready, s_req_ready;
  logic         a_blk_in_ready, b_blk_in_ready, s_blk_in_ready;
  logic         a_blk_out_valid, b_blk_out_valid, s_blk_out_valid;
  logic [127:0] a_blk_out_data, b_blk_out_data, s_blk_out_data;
  logic         a_done, b_done, s_done;
  logic         a_err, b_err, s_err;
  logic [1:0]   a_mode, b_mode, s_mode;
  logic [127:0] a_sector, b_sector, s_sector;
  logic         a_in_rdy, b_in_rdy, s_in_rdy;
  logic [127:0] a_data_in, b_data_in, s_data_in;

  logic sel;

  xex_sector_sequencer dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_dec(req_dec),
    .req_sector(req_sector), .req_nblk(req_nblk),
    .blk_in_valid(blk_in_valid), .blk_in_ready(a_blk_in_ready), .blk_in_data(blk_in_data),
    .blk_out_valid(a_blk_out_valid), .blk_out_ready(blk_out_ready), .blk_out_data(a_blk_out_data),
    .done(a_done), .err(a_err),
    .xex_mode(a_mode), .xex_sector(a_sector), .xex_in_rdy(a_in_rdy), .xex_data_in(a_data_in),
    .xex_busy(xex_busy), .xex_out_rdy(xex_out_rdy), .xex_data_out(xex_data_out)
  );

  xex_sector_sequencer #(.TIMEOUT(8)) dut_to (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_dec(req_dec),
    .req_sector(req_sector), .req_nblk(req_nblk),
    .blk_in_valid(blk_in_valid), .blk_in_ready(b_blk_in_ready), .blk_in_data(blk_in_data),
    .blk_out_valid(b_blk_out_valid), .blk_out_ready(blk_out_ready), .blk_out_data(b_blk_out_data),
    .done(b_done), .err(b_err),
    .xex_mode(b_mode), .xex_sector(b_sector), .xex_in_rdy(b_in_rdy), .xex_data_in(b_data_in),
    .xex_busy(xex_busy), .xex_out_rdy(xex_out_rdy), .xex_data_out(xex_data_out)
  );

  assign s_req_ready     = sel ? b_req_ready     : a_req_ready;
  assign s_blk_in_ready  = sel ? b_blk_in_ready  : a_blk_in_ready;
  assign s_blk_out_valid = sel ? b_blk_out_valid : a_blk_out_valid;
  assign s_blk_out_data  = sel ? b_blk_out_data  : a_blk_out_data;
  assign s_done          = sel ? b_done          : a_done;
  assign s_err           = sel ? b_err           : a_err;
  assign s_mode          = sel ? b_mode          : a_mode;
  assign s_sector        = sel ? b_sector        : a_sector;
  assign s_in_rdy        = sel ? b_in_rdy        : a_in_rdy;
  assign s_data_in       = sel ? b_data_in       : a_data_in;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // engine model knobs and state
  int           busy_len = 3;
  int           eng_lat  = 10;
  bit           eng_en   = 1'b1;
  int           tw_cnt   = 0;
  int           lat_cnt  = 0;
  logic [127:0] eng_buf  = '0;

  // monitor / scoreboard state
  logic [127:0] sb[$];
  logic         cur_dec = 1'b0;
  logic [127:0] cur_sector = '0;
  logic [127:0] last_in = '0;
  logic [127:0] held = '0;
  bit           prev_stall = 1'b0;
  bit           acc = 1'b0, in_hs = 1'b0, out_hs = 1'b0;
  int cyc = 0, acc_cyc = 0, inrdy_cyc = 0, out_cyc = 0, done_cyc = 0, err_cyc = 0;
  int n_inrdy = 0, n_out = 0, n_done = 0, n_err = 0, n_mode_on = 0, n_inready = 0, mode_bad = 0;
  logic [1:0]   err_mode = 2'b00;

  task automatic clear_stats();
    sb.delete();
    n_inrdy = 0; n_out = 0; n_done = 0; n_err = 0;
    n_mode_on = 0; n_inready = 0; mode_bad = 0;
    prev_stall = 1'b0;
  endtask

  // One cycle: engine responds to this cycle's DUT outputs, handshakes are scored,
  // then time advances to the next falling edge.
  task automatic tick();
    xex_out_rdy  = 1'b0;
    xex_data_out = {$urandom, $urandom, $urandom, $urandom};
    if (n_rst) begin
      tw_cnt = 0; lat_cnt = 0; xex_busy = 1'b0;
    end else begin
      if (s_mode == 2'b00) begin
        tw_cnt = 0; xex_busy = 1'b0;
      end else begin
        if (tw_cnt < 1000) tw_cnt++;
        xex_busy = (tw_cnt >= 2 && tw_cnt <= 1 + busy_len);
      end
      if (s_in_rdy) begin
        lat_cnt = eng_lat;
        eng_buf = s_data_in ^ s_sector ^ (s_mode[0] ? KD : KE);
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0 && eng_en) begin
          xex_out_rdy  = 1'b1;
          xex_data_out = eng_buf;
        end
      end
    end

    acc = req_valid && s_req_ready;
    if (acc) acc_cyc = cyc;
    in_hs = blk_in_valid && s_blk_in_ready;
    if (in_hs) begin
      last_in = blk_in_data;
      sb.push_back(blk_in_data ^ cur_sector ^ (cur_dec ? KD : KE));
    end
    if (s_in_rdy) begin
      n_inrdy++;
      inrdy_cyc = cyc;
      check("xex_data_in", s_data_in, last_in);
      check("mode_issue", s_mode, {1'b1, cur_dec});
    end
    if (s_mode != 2'b00) n_mode_on++;
    if (s_mode != 2'b00 && s_mode != {1'b1, cur_dec}) mode_bad++;
    if (s_blk_in_ready) n_inready++;
    out_hs = s_blk_out_valid && blk_out_ready;
    if (s_blk_out_valid && prev_stall) check("out_stable", s_blk_out_data, held);
    prev_stall = s_blk_out_valid && !blk_out_ready && !n_rst;
    held = s_blk_out_data;
    if (out_hs) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else check("blk_out_data", s_blk_out_data, sb.pop_front());
      n_out++;
      out_cyc = cyc;
    end
    if (s_done) begin n_done++; done_cyc = cyc; end
    if (s_err)  begin n_err++; err_cyc = cyc; err_mode = s_mode; end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
  endtask

  task automatic run_sector(input logic dec, input logic [127:0] sec, input logic [7:0] nblk,
                            input int stall_idx, input int stall_len, input int rst_idx,
                            input int budget);
    int fed  = 0;
    int left = stall_len;
    int b    = budget;
    bit fin  = 1'b0;
    cur_dec = dec; cur_sector = sec;
    req_valid = 1'b1; req_dec = dec; req_sector = sec; req_nblk = nblk;
    acc = 1'b0;
    while (!acc && b > 0) begin tick(); b--; end
    req_valid = 1'b0;
    if (!acc) begin
      check("req_accept", 0, 1);
      return;
    end
    check("mode_start", s_mode, (nblk == 8'd0) ? 2'b00 : {1'b1, dec});
    while (!fin && b > 0) begin
      if (!blk_in_valid && fed < int'(nblk)) begin
        blk_in_valid = 1'b1;
        blk_in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      blk_out_ready = 1'b1;
      if (s_blk_out_valid && n_out == stall_idx && left > 0) begin
        blk_out_ready = 1'b0;
        left--;
      end
      if (s_blk_out_valid && n_out == rst_idx) begin
        n_rst = 1'b1;
        blk_out_ready = 1'b0;
        fin = 1'b1;
      end
      tick();
      b--;
      if (in_hs) begin blk_in_valid = 1'b0; fed++; end
      if (n_done > 0 || n_err > 0) fin = 1'b1;
    end
    if (!fin) check("cycle_budget", 0, 1);
    n_rst = 1'b0; blk_in_valid = 1'b0; blk_out_ready = 1'b0;
  endtask

  task automatic finish_checks(input int nblk);
    check("inrdy_pulses", n_inrdy, nblk);
    check("out_count", n_out, nblk);
    check("done_count", n_done, 1);
    check("err_count", n_err, 0);
    check("sb_left", sb.size(), 0);
    check("mode_consistent", mode_bad, 0);
    check("done_lat", done_cyc - out_cyc, 1);
    check("req_ready_after", s_req_ready, 1);
    check("mode_idle", s_mode, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; n_rst = 1'b1;
    req_valid = 1'b0; req_dec = 1'b0; req_sector = '0; req_nblk = '0;
    blk_in_valid = 1'b0; blk_in_data = '0; blk_out_ready = 1'b0;
    xex_busy = 1'b0; xex_out_rdy = 1'b0; xex_data_out = '0;
    @(negedge clk);

    // reset state
    do_reset();
    check("rst_ctl", {s_done, s_err, s_mode, s_in_rdy, s_blk_in_ready, s_blk_out_valid}, '0);
    check("rst_data", s_data_in | s_blk_out_data | s_sector, '0);
    check("rst_req_ready", s_req_ready, 1);

    // single encrypt block, sector 5
    clear_stats(); busy_len = 3; eng_lat = 10; eng_en = 1'b1;
    run_sector(1'b0, 128'h5, 8'd1, -1, 0, -1, 200);
    finish_checks(1);

    // four-block decrypt with 5-cycle output stall on block 2
    clear_stats();
    run_sector(1'b1, {$urandom, $urandom, $urandom, $urandom}, 8'd4, 1, 5, -1, 400);
    finish_checks(4);

    // empty sector
    clear_stats();
    run_sector(1'b0, 128'h77, 8'd0, -1, 0, -1, 50);
    check("empty_done_count", n_done, 1);
    check("empty_done_lat_ok", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1);
    check("empty_mode_off", n_mode_on, 0);
    check("empty_no_in_ready", n_inready, 0);
    check("empty_req_ready", s_req_ready, 1);

    // reset during DRAIN of block 2 of 3
    clear_stats();
    run_sector(1'b1, 128'hdead_beef, 8'd3, -1, 0, 1, 400);
    check("mid_rst_ctl", {s_done, s_err, s_mode, s_in_rdy, s_blk_in_ready, s_blk_out_valid}, '0);
    check("mid_rst_data", s_data_in | s_blk_out_data | s_sector, '0);
    check("mid_rst_req_ready", s_req_ready, 1);
    for (int i = 0; i < 4; i++) tick();
    check("mid_rst_no_done", n_done, 0);
    check("mid_rst_no_err", n_err, 0);

    // timeout on the TIMEOUT=8 instance: engine never returns a result
    sel = 1'b1;
    do_reset();
    clear_stats(); eng_en = 1'b0; eng_lat = 10;
    run_sector(1'b0, 128'h1234, 8'd3, -1, 0, -1, 200);
    check("to_err_count", n_err, 1);
    check("to_done_count", n_done, 0);
    check("to_err_lat", err_cyc - (inrdy_cyc + 1), 8);
    check("to_err_mode", err_mode, 2'b00);
    check("to_blocks_fed", n_inrdy, 1);
    check("to_req_ready", s_req_ready, 1);

    // next request accepted; result arrives in the last allowed WAIT cycle
    clear_stats(); eng_en = 1'b1; eng_lat = 8;
    run_sector(1'b1, 128'h9999_0000_5555, 8'd1, -1, 0, -1, 200);
    finish_checks(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
